uart_transmitter: RTL
=====================

# uart_transmitter

Serial UART transmitter; the stage directly upstream of the receiver, driving the serial line the receiver samples. Accepts a byte over a four-phase req/ack handshake and shifts out an idle-high frame: start bit, 8 data bits LSB first, optional parity, one stop bit. Bit timing is a fixed count of `clk` cycles matching the receiver's bit period.

## Interface
- `CLKS_PER_BIT`, 18, clk cycles per serial bit; legal range 2..65535
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- `clk`  in  1  system clock, rising-edge
- `clr`  in  1  reset; one clock; reset is asynchronous and active-low
- `req`  in  1  upstream byte-valid request (four-phase)
- `data`  in  8  byte to send; must be stable while `req`=1 and `ack`=0
- `ack`  out  1  byte accepted; held until `req` observed low
- `tx`  out  1  serial line, idle high
- `busy`  out  1  frame in progress (START through STOP)

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Registers: 8-bit shift register, bit counter (0..7), baud counter sized to hold CLKS_PER_BIT-1, `ack` flag.
- IDLE: `tx`=1, `busy`=0. Accept when `req`=1 and `ack`=0: latch `data`, set `ack`, go START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with bit counter 0.
- DATA: `tx`=shift[0]; after CLKS_PER_BIT cycles shift right, increment counter; after bit 7 go PARITY (macro) or STOP.
- PARITY: `tx`= XOR of latched byte, XOR `PARITY_ODD`; CLKS_PER_BIT cycles, then STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE.
- `ack`: set on accept edge; cleared on the first edge where `req`=0 is sampled; independent of frame progress. A new byte is accepted only when state is IDLE and `ack`=0.
- `req` dropping or `data` changing after accept has no effect on the frame in flight.
- `req` held high after `ack` clears (protocol violation): no second accept until `req` returns low then high; `ack` stays 0 — accept requires `req`=1 with `ack`=0 only after a low phase has been observed (internal `req_seen_low` flag, set at reset).

## Timing
- Reset (`clr`=0, asynchronous): state IDLE, `tx`=1, `ack`=0, `busy`=0, counters 0, `req_seen_low`=1. Reset mid-frame abandons the frame; `tx` returns high immediately, no stop bit emitted.
- Accept at edge E: `ack`=1, `busy`=1, `tx`=0 all visible after E (all outputs registered).
- Bit n (start=0, data 1..8, parity 9, stop last) occupies edges E+n·CLKS_PER_BIT .. E+(n+1)·CLKS_PER_BIT.
- Frame length: 10·CLKS_PER_BIT cycles (11· with parity). `busy` falls at end of stop bit; earliest next accept is that same edge+1 if `ack`=0 and `req`=1.
- `ack` falls one edge after `req` first sampled low.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state present, 11-bit frame, `PARITY_ODD` honored.
- Undefined: no parity bit, 10-bit frame, `PARITY_ODD` ignored; receiver interoperates unchanged.

## Test plan
- Reset: `clr`=0 → `tx`=1, `ack`=0, `busy`=0; assert `clr` mid-frame → `tx`=1 same cycle, state IDLE.
- Send 0x12, CLKS_PER_BIT=18, no parity → `tx`: 0 for 18 cycles, then 0,1,0,0,1,0,0,0 each 18 cycles, 1 for 18; `busy` high exactly 180 cycles.
- Loopback into receiver (same `clk`, `clr`): send 0x12 then 0xA5 → receiver raises `req` with `data`=0x12, then 0xA5.
- Handshake: hold `req`=1 for 300 cycles → exactly one frame, `ack` high until cycle after `req` falls; change `data` mid-frame → frame unchanged.
- Parity (macro on, even): 0x12 → parity bit 0; 0x07 → 1; `PARITY_ODD`=1 inverts both; frame 198 cycles.
- Back-to-back: raise `req` for second byte during first frame's stop bit → second start bit begins the edge after `busy` falls, no idle gap beyond one cycle.

Source files
------------

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module     : uart_transmitter
//  Description: Serial UART transmitter. Accepts a byte over a four-phase
//               req/ack handshake and shifts out an idle-high frame:
//               start bit, 8 data bits LSB first, optional parity, stop bit.
//               Each bit lasts CLKS_PER_BIT clk cycles.
//               Optional parity bit: define UART_TX_PARITY_EN.
//  Revision   : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 18,   // 2..65535
    parameter bit PARITY_ODD   = 1'b0  // 0 = even, 1 = odd (parity builds only)
) (
    input  logic       clk,
    input  logic       clr,            // asynchronous, active-low
    input  logic       req,
    input  logic [7:0] data,
    output logic       ack,
    output logic       tx,
    output logic       busy
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_e;

    state_e              state_q, state_d;
    logic [c_BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                ack_q, ack_d;
    logic                seen_low_q, seen_low_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                w_accept;
    logic                w_baud_done;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`else
    // Parity sense has no effect without the parity bit; the empty block
    // keeps the parameter referenced in this build.
    if (PARITY_ODD) begin : g_parity_sense_unused
    end
`endif

    assign w_baud_done = (baud_q == c_BAUD_LAST);
    // A new byte needs an idle line, a retired ack and a low phase on req.
    assign w_accept    = (state_q == S_IDLE) && req && !ack_q && seen_low_q;

    // Next-state, handshake and registered-output precomputation.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ack_d      = ack_q;
        seen_low_d = seen_low_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        // Handshake runs independently of frame progress.
        if (w_accept) begin
            ack_d      = 1'b1;
            seen_low_d = 1'b0;
        end else if (!req) begin
            ack_d      = 1'b0;
            seen_low_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    shift_d = data;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data) ^ PARITY_ODD;
`endif
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + c_BAUD_ONE;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d  = baud_q + c_BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d  = baud_q + c_BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d  = baud_q + c_BAUD_ONE;
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = 3'd0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the upcoming state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers; reset abandons any frame.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            ack_q      <= 1'b0;
            seen_low_q <= 1'b1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ack_q      <= ack_d;
            seen_low_q <= seen_low_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign ack  = ack_q;
    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
`default_nettype wire
